shift_unit: RTL

Multi-cycle shifter for the KGP miniRISC execute stage. It handles sll/srl/sra and rotate-right operations: it captures an operand and shift amount on a start pulse, then shifts one bit position per clock. It reports completion with a one-cycle `done` pulse and holds the result until the next start. It is the consumer side of the shift-operand registers: the datapath flip-flops latch the operand, and this block reads it out and transforms it over several cycles. The control unit stalls the pipeline while `busy` is high.

---
 rtl/shift_unit.sv | 92 +++++++++
 1 files changed

// File: rtl/shift_unit.sv
// Multi-cycle sll/srl/sra/ror shifter: one bit per clock, done pulse on completion.
// Define SHIFT_UNIT_FAST_EN to step by 4 positions while at least 4 remain.
module shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic [0:0]       state_reg;
  logic [SHW-1:0]   cnt_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] result_reg;
  logic             done_reg;

  function automatic logic [WIDTH-1:0] step1(input logic [1:0] o, input logic [WIDTH-1:0] v);
    case (o)
      OP_SLL:  step1 = {v[WIDTH-2:0], 1'b0};
      OP_SRL:  step1 = {1'b0, v[WIDTH-1:1]};
      OP_SRA:  step1 = {v[WIDTH-1], v[WIDTH-1:1]};
      default: step1 = {v[0], v[WIDTH-1:1]};
    endcase
  endfunction

`ifdef SHIFT_UNIT_FAST_EN
  function automatic logic [WIDTH-1:0] step4(input logic [1:0] o, input logic [WIDTH-1:0] v);
    case (o)
      OP_SLL:  step4 = {v[WIDTH-5:0], 4'b0000};
      OP_SRL:  step4 = {4'b0000, v[WIDTH-1:4]};
      OP_SRA:  step4 = {{4{v[WIDTH-1]}}, v[WIDTH-1:4]};
      default: step4 = {v[3:0], v[WIDTH-1:4]};
    endcase
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            result_reg <= operand;
            cnt_reg    <= shamt;
            op_reg     <= op;
            state_reg  <= SHIFT;
          end
        end
        default: begin
          // Amounts >= WIDTH are not clamped; stepping naturally saturates or wraps.
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
`ifdef SHIFT_UNIT_FAST_EN
          end else if (cnt_reg >= SHW'(4)) begin
            result_reg <= step4(op_reg, result_reg);
            cnt_reg    <= cnt_reg - SHW'(4);
`endif
          end else begin
            result_reg <= step1(op_reg, result_reg);
            cnt_reg    <= cnt_reg - SHW'(1);
          end
        end
      endcase
    end
  end

  assign busy   = (state_reg == SHIFT);
  assign done   = done_reg;
  assign result = result_reg;

endmodule
